// File: rtl/hnf_req_tracker_pkg.sv
// hnf_req_tracker_pkg: CHI request flit layout plus HN-F tracker state and line-address helper.
package hnf_req_tracker_pkg;
   localparam int ADDR_W = 48;
   typedef struct packed {
      logic [3:0]        qos;
      logic [10:0]       tgtid;
      logic [10:0]       srcid;
      logic [11:0]       txnid;
      logic [6:0]        opcode;
      logic [ADDR_W-1:0] addr;
   } reqflit_t;
   typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_ACTIVE} trk_state_e;
   function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] addr, input int unsigned off);
      return addr >> off;
   endfunction
endpackage

// File: rtl/hnf_rr_arbiter.sv
// hnf_rr_arbiter: round-robin pick of the first request at or after i_ptr, wrapping; WIDTH must be a power of two.
module hnf_rr_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]         i_req,
   input  logic [$clog2(WIDTH)-1:0] i_ptr,
   output logic [WIDTH-1:0]         o_gnt,
   output logic [$clog2(WIDTH)-1:0] o_idx,
   output logic                     o_valid
);
   localparam int IW = $clog2(WIDTH);
   always_comb begin
      o_idx = '0;
      o_valid = 1'b0;
      // Scan downward so the lowest offset from the pointer wins.
      for (int k = WIDTH - 1; k >= 0; k--)
         if (i_req[IW'(i_ptr + IW'(k))]) begin
            o_idx = IW'(i_ptr + IW'(k));
            o_valid = 1'b1;
         end
      o_gnt = o_valid ? WIDTH'(1) << o_idx : '0;
   end
endmodule

// File: rtl/hnf_req_tracker.sv
// hnf_req_tracker: pops posting-queue flits into tracker entries, serialises same-line requests
// through a dependency matrix and issues hazard-free entries round-robin until completion.
module hnf_req_tracker
   import hnf_req_tracker_pkg::*;
#(
   parameter int NUM_ENTRIES = 8,
   parameter int LINE_OFFSET = 6
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic [$bits(reqflit_t)-1:0]          i_in_flit,
   input  logic                                 i_in_valid,
   output logic                                 o_in_ready,
   output logic [$bits(reqflit_t)-1:0]          o_issue_flit,
   output logic [$clog2(NUM_ENTRIES)-1:0]       o_issue_idx,
   output logic                                 o_issue_valid,
   input  logic                                 i_issue_ready,
   input  logic                                 i_dealloc_valid,
   input  logic [$clog2(NUM_ENTRIES)-1:0]       i_dealloc_idx,
   output logic [$clog2(NUM_ENTRIES+1)-1:0]     o_occupancy
);
   localparam int IW = $clog2(NUM_ENTRIES);
   localparam int OW = $clog2(NUM_ENTRIES + 1);
   trk_state_e             r_state     [NUM_ENTRIES];
   trk_state_e             w_state_nxt [NUM_ENTRIES];
   reqflit_t               r_flit      [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] r_dep       [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] w_free, w_elig, w_hit, w_gnt, w_sel, w_clr;
   logic [IW-1:0]          r_rr_ptr, r_lock_idx, w_alloc_idx, w_arb_idx, w_issue_idx;
   logic [OW-1:0]          r_occ;
   logic                   r_lock, w_arb_valid, w_alloc, w_dealloc, w_issue;
   reqflit_t               w_in;
   assign w_in      = reqflit_t'(i_in_flit);
   assign w_alloc   = i_in_valid && o_in_ready;
   assign w_dealloc = i_dealloc_valid && r_state[i_dealloc_idx] == ST_ACTIVE;
   assign w_clr     = w_dealloc ? NUM_ENTRIES'(1) << i_dealloc_idx : '0;
   assign w_issue   = o_issue_valid && i_issue_ready;
   assign w_issue_idx = r_lock ? r_lock_idx : w_arb_idx;
   always_comb begin
      w_alloc_idx = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--)
         if (w_free[i]) w_alloc_idx = IW'(i);
   end
   for (genvar e = 0; e < NUM_ENTRIES; e++) begin : g_entry
      assign w_free[e] = r_state[e] == ST_FREE;
      assign w_elig[e] = r_state[e] == ST_WAIT && r_dep[e] == '0;
      assign w_hit[e]  = !w_free[e] && line_addr(r_flit[e].addr, LINE_OFFSET) == line_addr(w_in.addr, LINE_OFFSET);
      assign w_sel[e]  = r_lock ? r_lock_idx == IW'(e) : w_gnt[e];
      // Alloc, issue and dealloc always target distinct entries (FREE / WAIT / ACTIVE).
      assign w_state_nxt[e] = (w_alloc && w_alloc_idx == IW'(e)) ? ST_WAIT :
                              (w_issue && w_sel[e])              ? ST_ACTIVE :
                              w_clr[e]                           ? ST_FREE : r_state[e];
   end
   hnf_rr_arbiter #(.WIDTH(NUM_ENTRIES)) u_arb (
      .i_req   (w_elig),
      .i_ptr   (r_rr_ptr),
      .o_gnt   (w_gnt),
      .o_idx   (w_arb_idx),
      .o_valid (w_arb_valid)
   );
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            r_state[i] <= ST_FREE;
            r_dep[i]   <= '0;
         end
         r_lock     <= 1'b0;
         r_lock_idx <= '0;
         r_rr_ptr   <= '0;
         r_occ      <= '0;
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            r_state[i] <= w_state_nxt[i];
            r_dep[i]   <= ((w_alloc && w_alloc_idx == IW'(i)) ? w_hit : r_dep[i]) & ~w_clr;
         end
         r_lock     <= o_issue_valid && !i_issue_ready;
         r_lock_idx <= w_issue_idx;
         if (w_issue) r_rr_ptr <= w_issue_idx + IW'(1);
         r_occ      <= r_occ + OW'(w_alloc) - OW'(w_dealloc);
      end
   end
   always_ff @(posedge clock)
      for (int i = 0; i < NUM_ENTRIES; i++)
         if (w_alloc && w_alloc_idx == IW'(i)) r_flit[i] <= w_in;
   always_comb begin
      o_in_ready    = |w_free;
      o_issue_valid = r_lock || w_arb_valid;
      o_issue_idx   = w_issue_idx;
      o_issue_flit  = r_flit[w_issue_idx];
      o_occupancy   = r_occ;
   end
   always_ff @(posedge clock)
      if (!reset && i_dealloc_valid)
         assert (r_state[i_dealloc_idx] == ST_ACTIVE)
         else $error("dealloc of non-active entry %0d", i_dealloc_idx);
endmodule

// File: tb/tb_hnf_req_tracker.sv
// tb_hnf_req_tracker: table-driven vectors plus directed sequences for stall, full and reset cases.
module tb_hnf_req_tracker;
   import hnf_req_tracker_pkg::*;
   localparam int FW = $bits(reqflit_t);
   typedef struct {
      logic        v;
      logic [47:0] a;
      logic        ir;
      logic        dv;
      logic [2:0]  di;
      logic        e_rdy;
      logic        e_iv;
      logic [2:0]  e_idx;
      logic [47:0] e_addr;
      logic [3:0]  e_occ;
   } vec_t;
   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [FW-1:0] in_flit = '0;
   logic          in_valid = 1'b0, issue_ready = 1'b0, dealloc_valid = 1'b0;
   logic [2:0]    dealloc_idx = '0;
   logic          in_ready, issue_valid;
   logic [FW-1:0] issue_flit;
   logic [2:0]    issue_idx;
   logic [3:0]    occupancy;
   reqflit_t      f_iss;
   int            total = 0, bad = 0;
   vec_t          tbl [23];
   assign f_iss = reqflit_t'(issue_flit);
   hnf_req_tracker #(.NUM_ENTRIES(8), .LINE_OFFSET(6)) dut (
      .clock           (clock),
      .reset           (reset),
      .i_in_flit       (in_flit),
      .i_in_valid      (in_valid),
      .o_in_ready      (in_ready),
      .o_issue_flit    (issue_flit),
      .o_issue_idx     (issue_idx),
      .o_issue_valid   (issue_valid),
      .i_issue_ready   (issue_ready),
      .i_dealloc_valid (dealloc_valid),
      .i_dealloc_idx   (dealloc_idx),
      .o_occupancy     (occupancy)
   );
   always #5 clock = ~clock;
   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic drive(input logic v, input logic [47:0] a, input logic ir, input logic dv, input logic [2:0] di);
      reqflit_t f;
      f = '0;
      f.addr = a;
      f.opcode = 7'h01;
      f.txnid = a[23:12];
      in_flit = f;
      in_valid = v;
      issue_ready = ir;
      dealloc_valid = dv;
      dealloc_idx = di;
      @(posedge clock);
      #1;
   endtask
   task automatic expect_out(input string tag, input logic rdy, input logic iv, input logic [2:0] idx,
                             input logic [47:0] addr, input logic [3:0] occ);
      chk({tag, " in_ready"}, in_ready, rdy);
      chk({tag, " issue_valid"}, issue_valid, iv);
      chk({tag, " occupancy"}, occupancy, occ);
      if (iv) begin
         chk({tag, " issue_idx"}, issue_idx, idx);
         chk({tag, " issue_addr"}, f_iss.addr, addr);
      end
   endtask
   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, 48'h0, 1'b0, 1'b0, 3'd0);
      reset = 1'b0;
   endtask
   initial begin
      //          v  addr       ir dv di  rdy iv idx addr      occ
      tbl[0]  = '{0, 48'h0,     1, 0, 0,  1,  0, 0, 48'h0,     0};
      tbl[1]  = '{1, 48'h1000,  1, 0, 0,  1,  0, 0, 48'h0,     0};
      tbl[2]  = '{0, 48'h0,     1, 0, 0,  1,  1, 0, 48'h1000,  1};
      tbl[3]  = '{0, 48'h0,     1, 1, 0,  1,  0, 0, 48'h0,     1};
      tbl[4]  = '{0, 48'h0,     1, 0, 0,  1,  0, 0, 48'h0,     0};
      tbl[5]  = '{1, 48'h1000,  1, 0, 0,  1,  0, 0, 48'h0,     0};
      tbl[6]  = '{1, 48'h1020,  1, 0, 0,  1,  1, 0, 48'h1000,  1};
      tbl[7]  = '{0, 48'h0,     1, 0, 0,  1,  0, 0, 48'h0,     2};
      tbl[8]  = '{0, 48'h0,     1, 1, 0,  1,  0, 0, 48'h0,     2};
      tbl[9]  = '{0, 48'h0,     1, 0, 0,  1,  1, 1, 48'h1020,  1};
      tbl[10] = '{0, 48'h0,     1, 1, 1,  1,  0, 0, 48'h0,     1};
      tbl[11] = '{0, 48'h0,     1, 0, 0,  1,  0, 0, 48'h0,     0};
      tbl[12] = '{1, 48'h4000,  1, 0, 0,  1,  0, 0, 48'h0,     0};
      tbl[13] = '{0, 48'h0,     1, 0, 0,  1,  1, 0, 48'h4000,  1};
      tbl[14] = '{1, 48'h4010,  1, 1, 0,  1,  0, 0, 48'h0,     1};
      tbl[15] = '{0, 48'h0,     1, 0, 0,  1,  1, 1, 48'h4010,  1};
      tbl[16] = '{0, 48'h0,     1, 1, 1,  1,  0, 0, 48'h0,     1};
      tbl[17] = '{1, 48'h5000,  1, 0, 0,  1,  0, 0, 48'h0,     0};
      tbl[18] = '{1, 48'h6000,  1, 0, 0,  1,  1, 0, 48'h5000,  1};
      tbl[19] = '{1, 48'h7000,  1, 1, 0,  1,  1, 1, 48'h6000,  2};
      tbl[20] = '{0, 48'h0,     1, 1, 1,  1,  1, 2, 48'h7000,  2};
      tbl[21] = '{0, 48'h0,     1, 1, 2,  1,  0, 0, 48'h0,     1};
      tbl[22] = '{0, 48'h0,     1, 0, 0,  1,  0, 0, 48'h0,     0};
      drive(1'b0, 48'h0, 1'b0, 1'b0, 3'd0);
      do_reset();
      for (int i = 0; i < 23; i++) begin
         expect_out($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_iv, tbl[i].e_idx, tbl[i].e_addr, tbl[i].e_occ);
         drive(tbl[i].v, tbl[i].a, tbl[i].ir, tbl[i].dv, tbl[i].di);
      end
      // Grant held stable while the pipeline stalls, then in-order release.
      do_reset();
      expect_out("stall0", 1, 0, 0, 48'h0, 0);
      drive(1'b1, 48'h1000, 1'b0, 1'b0, 3'd0);
      expect_out("stall1", 1, 1, 0, 48'h1000, 1);
      drive(1'b1, 48'h2000, 1'b0, 1'b0, 3'd0);
      expect_out("stall2", 1, 1, 0, 48'h1000, 2);
      drive(1'b1, 48'h3000, 1'b0, 1'b0, 3'd0);
      expect_out("stall3", 1, 1, 0, 48'h1000, 3);
      drive(1'b0, 48'h0, 1'b1, 1'b0, 3'd0);
      expect_out("rel1", 1, 1, 1, 48'h2000, 3);
      drive(1'b0, 48'h0, 1'b1, 1'b0, 3'd0);
      expect_out("rel2", 1, 1, 2, 48'h3000, 3);
      drive(1'b0, 48'h0, 1'b1, 1'b0, 3'd0);
      expect_out("rel3", 1, 0, 0, 48'h0, 3);
      for (int i = 0; i < 3; i++) drive(1'b0, 48'h0, 1'b0, 1'b1, 3'(i));
      expect_out("drained", 1, 0, 0, 48'h0, 0);
      // Fill every entry, refuse while full, reuse a freed slot.
      do_reset();
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("fill%0d in_ready", k), in_ready, 1'b1);
         chk($sformatf("fill%0d occupancy", k), occupancy, 48'(k));
         drive(1'b1, 48'(k + 1) << 16, 1'b1, 1'b0, 3'd0);
      end
      expect_out("fill_last", 0, 1, 7, 48'h80000, 8);
      drive(1'b0, 48'h0, 1'b1, 1'b0, 3'd0);
      expect_out("full", 0, 0, 0, 48'h0, 8);
      drive(1'b1, 48'hAA000, 1'b1, 1'b0, 3'd0);
      expect_out("full_hold", 0, 0, 0, 48'h0, 8);
      drive(1'b0, 48'h0, 1'b0, 1'b1, 3'd5);
      expect_out("freed5", 1, 0, 0, 48'h0, 7);
      drive(1'b1, 48'h90000, 1'b0, 1'b0, 3'd0);
      expect_out("reuse5", 0, 1, 5, 48'h90000, 8);
      // Reset mid-handshake discards entries and the held grant.
      do_reset();
      for (int k = 0; k < 4; k++) drive(1'b1, 48'(k + 1) << 12, 1'b0, 1'b0, 3'd0);
      expect_out("pre_rst", 1, 1, 0, 48'h1000, 4);
      reset = 1'b1;
      drive(1'b1, 48'h8000, 1'b1, 1'b0, 3'd0);
      reset = 1'b0;
      expect_out("post_rst", 1, 0, 0, 48'h0, 0);
      drive(1'b1, 48'h1000, 1'b0, 1'b0, 3'd0);
      expect_out("after_rst", 1, 1, 0, 48'h1000, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
